// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 host command sequencer: FSM states,
// device response bytes and completion status codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_ACK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_RETRY   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADRESP = 2'd3
  } status_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

endpackage

// File: rtl/ps2_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ps2_timer #(
  parameter int unsigned COUNT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(COUNT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(COUNT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ps2_cmd_seq.sv
// PS/2 host-to-device command sequencer: sends a command byte plus optional
// argument byte, checks ACK/RESEND replies, retries, and reports one status.
module ps2_cmd_seq
  import ps2_pkg::*;
#(
  parameter int unsigned CLK        = 50,
  parameter int unsigned TIMEOUT_US = 20000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  input  logic [7:0] cmd_data,
  input  logic       cmd_arg_vld,
  input  logic [7:0] cmd_arg,
  output logic       cmd_rdy,
  output logic       done,
  output logic [1:0] done_status,
  output logic [7:0] done_resp,
  output logic       tx_send_req,
  output logic [7:0] tx_send_data,
  input  logic       tx_send_idle,
  input  logic       rx_vld,
  input  logic [7:0] rx_data
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  state_t        state, state_n;
  logic          byte_sel, byte_sel_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [7:0]    cmd_q, cmd_n;
  logic [7:0]    arg_q, arg_n;
  logic          arg_vld_q, arg_vld_n;
  logic          rdy_n, done_n, req_n;
  logic [1:0]    status_n;
  logic [7:0]    resp_n, data_n;
  logic          timer_load, timer_en, expired, resend;

  ps2_timer #(
    .COUNT(CLK * TIMEOUT_US)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expired(expired)
  );

  assign timer_en = (state == SEND) || (state == WAIT_TX) || (state == WAIT_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_sel     <= 1'b0;
      retry_cnt    <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      arg_vld_q    <= 1'b0;
      cmd_rdy      <= 1'b1;
      done         <= 1'b0;
      done_status  <= ST_OK;
      done_resp    <= '0;
      tx_send_req  <= 1'b0;
      tx_send_data <= '0;
    end else begin
      state        <= state_n;
      byte_sel     <= byte_sel_n;
      retry_cnt    <= retry_n;
      cmd_q        <= cmd_n;
      arg_q        <= arg_n;
      arg_vld_q    <= arg_vld_n;
      cmd_rdy      <= rdy_n;
      done         <= done_n;
      done_status  <= status_n;
      done_resp    <= resp_n;
      tx_send_req  <= req_n;
      tx_send_data <= data_n;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_n    = state;
    byte_sel_n = byte_sel;
    retry_n    = retry_cnt;
    cmd_n      = cmd_q;
    arg_n      = arg_q;
    arg_vld_n  = arg_vld_q;
    rdy_n      = cmd_rdy;
    done_n     = 1'b0;
    status_n   = done_status;
    resp_n     = done_resp;
    req_n      = tx_send_req;
    data_n     = tx_send_data;
    timer_load = 1'b0;
    resend     = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          cmd_n      = cmd_data;
          arg_n      = cmd_arg;
          arg_vld_n  = cmd_arg_vld;
          byte_sel_n = 1'b0;
          retry_n    = '0;
          resp_n     = '0;
          status_n   = ST_OK;
          rdy_n      = 1'b0;
          req_n      = 1'b1;
          data_n     = cmd_data;
          timer_load = 1'b1;
          state_n    = SEND;
        end
      end

      SEND: begin
        if (expired) begin
          req_n    = 1'b0;
          status_n = ST_TIMEOUT;
          done_n   = 1'b1;
          state_n  = DONE;
        end else if (!tx_send_idle) begin
          req_n   = 1'b0;
          state_n = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (expired) begin
          status_n = ST_TIMEOUT;
          done_n   = 1'b1;
          state_n  = DONE;
        end else if (tx_send_idle) begin
          state_n = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (rx_vld) begin
          resp_n = rx_data;
          if (rx_data == PS2_ACK) begin
            if (!byte_sel && arg_vld_q) begin
              byte_sel_n = 1'b1;
              retry_n    = '0;
              req_n      = 1'b1;
              data_n     = arg_q;
              timer_load = 1'b1;
              state_n    = SEND;
            end else begin
              status_n = ST_OK;
              done_n   = 1'b1;
              state_n  = DONE;
            end
          end else if (rx_data == PS2_RESEND) begin
            resend = 1'b1;
          end else begin
            status_n = ST_BADRESP;
            done_n   = 1'b1;
            state_n  = DONE;
          end
        end else if (expired) begin
          resend = 1'b1;
        end

        if (resend) begin
          if (retry_cnt < MAX_R) begin
            retry_n    = retry_cnt + RW'(1);
            req_n      = 1'b1;
            data_n     = byte_sel ? arg_q : cmd_q;
            timer_load = 1'b1;
            state_n    = SEND;
          end else begin
            status_n = ST_RETRY;
            done_n   = 1'b1;
            state_n  = DONE;
          end
        end
      end

      DONE: begin
        rdy_n   = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Bench for ps2_cmd_seq: table of commands with scripted device replies,
// plus hand sequences for stuck transmit, mid-command reset and stray rx.
module tb_ps2_cmd_seq;

  localparam int unsigned N = 100;  // CLK(50) * TIMEOUT_US(2)
  localparam logic [8:0] SIL = 9'h100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic [7:0] cmd_data;
  logic       cmd_arg_vld;
  logic [7:0] cmd_arg;
  logic       cmd_rdy;
  logic       done;
  logic [1:0] done_status;
  logic [7:0] done_resp;
  logic       tx_send_req;
  logic [7:0] tx_send_data;
  logic       tx_send_idle;
  logic       rx_vld;
  logic [7:0] rx_data;

  int total = 0;
  int bad   = 0;

  ps2_cmd_seq #(
    .CLK(50),
    .TIMEOUT_US(2),
    .MAX_RETRY(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_vld     (cmd_vld),
    .cmd_data    (cmd_data),
    .cmd_arg_vld (cmd_arg_vld),
    .cmd_arg     (cmd_arg),
    .cmd_rdy     (cmd_rdy),
    .done        (done),
    .done_status (done_status),
    .done_resp   (done_resp),
    .tx_send_req (tx_send_req),
    .tx_send_data(tx_send_data),
    .tx_send_idle(tx_send_idle),
    .rx_vld      (rx_vld),
    .rx_data     (rx_data)
  );

  always #5 clk = ~clk;

  // replies[i] answers the i-th transmission; bit 8 set means the device stays silent.
  typedef struct packed {
    logic [7:0]      cmd;
    logic            arg_vld;
    logic [7:0]      arg;
    logic [3:0][8:0] replies;
    logic [2:0]      ntx;
    logic [3:0][7:0] tx;
    logic [1:0]      st;
    logic [7:0]      resp;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c, input logic av, input logic [7:0] a,
                              input logic [8:0] r0, input logic [8:0] r1,
                              input logic [8:0] r2, input logic [8:0] r3,
                              input logic [2:0] n, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input logic [7:0] t3,
                              input logic [1:0] s, input logic [7:0] rs);
    vec_t m;
    m.cmd = c; m.arg_vld = av; m.arg = a;
    m.replies[0] = r0; m.replies[1] = r1; m.replies[2] = r2; m.replies[3] = r3;
    m.ntx = n;
    m.tx[0] = t0; m.tx[1] = t1; m.tx[2] = t2; m.tx[3] = t3;
    m.st = s; m.resp = rs;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int busy = 0, wait_r = 0, slot = 0, tx_n = 0, g;
    bit seen = 0, fin = 0;
    int txc[4];
    logic [7:0] txb[4];
    cmd_vld = 1'b1; cmd_data = v.cmd; cmd_arg_vld = v.arg_vld; cmd_arg = v.arg;
    step();
    cmd_vld = 1'b0;
    chk("accept_rdy_low", cmd_rdy, 0);
    for (int c = 0; c < 2000; c++) begin
      rx_vld = 1'b0;
      if (seen) begin
        chk("done_one_cycle", done, 0);
        chk("rdy_back", cmd_rdy, 1);
        chk("status_hold", done_status, v.st);
        fin = 1;
        break;
      end
      if (done) begin
        seen = 1;
        chk("status", done_status, v.st);
        chk("resp", done_resp, v.resp);
        chk("req_low_at_done", tx_send_req, 0);
      end
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          tx_send_idle = 1'b1;
          slot = tx_n - 1;
          if (slot < 4 && !v.replies[slot][8]) wait_r = 3;
        end
      end else if (tx_send_req && tx_send_idle) begin
        if (tx_n < 4) begin
          txb[tx_n] = tx_send_data;
          txc[tx_n] = c;
        end
        tx_n++;
        tx_send_idle = 1'b0;
        busy = 6;
      end
      if (wait_r > 0) begin
        wait_r--;
        if (wait_r == 0) begin
          rx_vld = 1'b1;
          rx_data = v.replies[slot][7:0];
        end
      end
      step();
    end
    rx_vld = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL no_done: got none want done within 2000 cycles");
    end
    chk("tx_count", tx_n, v.ntx);
    for (int i = 0; i < 4; i++) begin
      if (i < tx_n && i < int'(v.ntx)) chk("tx_byte", txb[i], v.tx[i]);
      if (i > 0 && i < tx_n && v.replies[i-1][8]) begin
        g = txc[i] - txc[i-1];
        total++;
        if (g < int'(N) || g > int'(N) + 1) begin
          bad++;
          $display("FAIL retry_gap: got %0d want %0d..%0d", g, N, N + 1);
        end
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    int t, reqs, dn;
    bit prev_req;

    vecs[0] = mk(8'hF4, 0, 8'h00, 9'h0FA, SIL, SIL, SIL, 1, 8'hF4, 0, 0, 0, 2'd0, 8'hFA);
    vecs[1] = mk(8'hED, 1, 8'h07, 9'h0FA, 9'h0FA, SIL, SIL, 2, 8'hED, 8'h07, 0, 0, 2'd0, 8'hFA);
    vecs[2] = mk(8'hFF, 0, 8'h00, 9'h0FE, 9'h0FE, 9'h0FA, SIL, 3, 8'hFF, 8'hFF, 8'hFF, 0, 2'd0, 8'hFA);
    vecs[3] = mk(8'hFF, 0, 8'h00, 9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE, 4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd1, 8'hFE);
    vecs[4] = mk(8'hF3, 1, 8'h20, SIL, SIL, SIL, SIL, 4, 8'hF3, 8'hF3, 8'hF3, 8'hF3, 2'd1, 8'h00);
    vecs[5] = mk(8'hF2, 0, 8'h00, 9'h0AA, SIL, SIL, SIL, 1, 8'hF2, 0, 0, 0, 2'd3, 8'hAA);
    vecs[6] = mk(8'hED, 1, 8'h02, 9'h0FA, 9'h0FE, 9'h0FA, SIL, 3, 8'hED, 8'h02, 8'h02, 0, 2'd0, 8'hFA);
    vecs[7] = mk(8'hED, 1, 8'h05, 9'h0FE, 9'h0FA, 9'h0AA, SIL, 3, 8'hED, 8'hED, 8'h05, 0, 2'd3, 8'hAA);
    vecs[8] = mk(8'hF3, 1, 8'h0A, 9'h0FA, SIL, 9'h0FE, 9'h0FA, 4, 8'hF3, 8'h0A, 8'h0A, 8'h0A, 2'd0, 8'hFA);

    rst = 1'b1; cmd_vld = 1'b0; cmd_data = '0; cmd_arg_vld = 1'b0; cmd_arg = '0;
    tx_send_idle = 1'b1; rx_vld = 1'b0; rx_data = '0;
    step(); step();
    chk("rst_rdy", cmd_rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_status", done_status, 0);
    chk("rst_resp", done_resp, 0);
    chk("rst_req", tx_send_req, 0);
    chk("rst_data", tx_send_data, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Unsolicited byte while idle must not disturb anything.
    rx_vld = 1'b1; rx_data = 8'h55;
    step();
    rx_vld = 1'b0;
    step(); step();
    chk("stray_rdy", cmd_rdy, 1);
    chk("stray_req", tx_send_req, 0);
    chk("stray_done", done, 0);
    chk("stray_resp_hold", done_resp, 8'hFA);

    // Transmit core never returns idle; a busy-time command must be ignored.
    cmd_vld = 1'b1; cmd_data = 8'hF5; cmd_arg_vld = 1'b0;
    step();
    chk("stuck_req", tx_send_req, 1);
    tx_send_idle = 1'b0;
    cmd_data = 8'h11;
    t = 0; reqs = 0; prev_req = 1'b1;
    while (!done && t < 400) begin
      if (tx_send_req && !prev_req) reqs++;
      prev_req = tx_send_req;
      step();
      t++;
    end
    cmd_vld = 1'b0;
    total++;
    if (t < int'(N) || t > int'(N) + 1) begin
      bad++;
      $display("FAIL stuck_latency: got %0d want %0d..%0d", t, N, N + 1);
    end
    chk("stuck_status", done_status, 2);
    chk("stuck_resp", done_resp, 0);
    chk("stuck_req_low", tx_send_req, 0);
    chk("stuck_no_resend", reqs, 0);
    step();
    tx_send_idle = 1'b1;
    chk("stuck_rdy_back", cmd_rdy, 1);
    step();

    // Reset while waiting for the device reply.
    cmd_vld = 1'b1; cmd_data = 8'hF4; cmd_arg_vld = 1'b0;
    step();
    cmd_vld = 1'b0;
    tx_send_idle = 1'b0;
    for (int i = 0; i < 6; i++) step();
    tx_send_idle = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rdy", cmd_rdy, 1);
    chk("mid_rst_req", tx_send_req, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_resp", done_resp, 0);
    reqs = 0; dn = 0;
    for (int i = 0; i < 150; i++) begin
      if (done) dn++;
      if (tx_send_req) reqs++;
      step();
    end
    chk("mid_rst_no_done", dn, 0);
    chk("mid_rst_no_req", reqs, 0);

    run_cmd(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
